// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: drains the UART receiver FIFO, parses HDR/LEN/payload/CSUM
// frames and streams checksum-clean payloads out over valid/ready.
module rx_frame_ctrl #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 1000000,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_ready,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_read,
    output logic        o_pl_valid,
    output logic [7:0]  o_pl_data,
    output logic        o_pl_last,
    input  logic        i_pl_ready,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [1:0]  o_err_code,
    output logic        o_busy,
    output logic [15:0] o_ok_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {StHunt, StLen, StData, StCsum, StEmit} state_e;

    state_e          state_q;
    logic [7:0]      len_q;
    logic [7:0]      idx_q;
    logic [7:0]      sum_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      pl_buf_q [MAX_LEN];
    logic            frame_ok_q;
    logic            frame_err_q;
    logic [1:0]      err_code_q;
    logic [15:0]     ok_cnt_q;
    logic [15:0]     err_cnt_q;

    logic            rx_read;
    logic            tmo_hit;
    logic            last_idx;
    logic [7:0]      sum_next;
    logic            err_now;
    logic [1:0]      err_code_d;

    // Pop strobe and shared decodes; reset gates the strobe so nothing is popped mid-reset.
    always_comb begin
        rx_read  = i_rx_ready && !i_rst &&
                   (state_q inside {StHunt, StLen, StData, StCsum});
        tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
        last_idx = (idx_q == len_q - 8'd1);
        sum_next = sum_q + i_rx_data;
    end

    // Error decision for the current cycle; a pop always beats timeout expiry.
    always_comb begin
        err_now    = 1'b0;
        err_code_d = 2'd0;
        case (state_q)
            StLen: begin
                if (rx_read) begin
                    if (i_rx_data == 8'd0 || i_rx_data > 8'(MAX_LEN)) begin
                        err_now    = 1'b1;
                        err_code_d = 2'd1;
                    end
                end else if (tmo_hit) begin
                    err_now    = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            StData: begin
                if (!rx_read && tmo_hit) begin
                    err_now    = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            StCsum: begin
                if (rx_read) begin
                    if (sum_next != 8'd0) begin
                        err_now    = 1'b1;
                        err_code_d = 2'd2;
                    end
                end else if (tmo_hit) begin
                    err_now    = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            default: ;
        endcase
    end

    // Frame FSM with registered pulses, error code and counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StHunt;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            sum_q       <= 8'd0;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            ok_cnt_q    <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (err_now) begin
                state_q     <= StHunt;
                tmo_q       <= '0;
                frame_err_q <= 1'b1;
                err_code_q  <= err_code_d;
                err_cnt_q   <= err_cnt_q + 16'd1;
            end else begin
                case (state_q)
                    StHunt: begin
                        tmo_q <= '0;
                        if (rx_read && i_rx_data == HDR) state_q <= StLen;
                    end
                    StLen: begin
                        if (rx_read) begin
                            tmo_q   <= '0;
                            len_q   <= i_rx_data;
                            sum_q   <= i_rx_data;
                            idx_q   <= 8'd0;
                            state_q <= StData;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StData: begin
                        if (rx_read) begin
                            tmo_q <= '0;
                            sum_q <= sum_next;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q + 8'd1 == len_q) state_q <= StCsum;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StCsum: begin
                        if (rx_read) begin
                            tmo_q   <= '0;
                            idx_q   <= 8'd0;
                            state_q <= StEmit;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StEmit: begin
                        tmo_q <= '0;
                        if (i_pl_ready) begin
                            if (last_idx) begin
                                frame_ok_q <= 1'b1;
                                ok_cnt_q   <= ok_cnt_q + 16'd1;
                                idx_q      <= 8'd0;
                                state_q    <= StHunt;
                            end else begin
                                idx_q <= idx_q + 8'd1;
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    // Payload buffer; idx stays below len (<= MAX_LEN) so the index never overruns.
    always_ff @(posedge i_clk) begin
        if (state_q == StData && rx_read) pl_buf_q[idx_q[IW-1:0]] <= i_rx_data;
    end

    // Output decode straight from registered state.
    always_comb begin
        o_rx_read   = rx_read;
        o_pl_valid  = (state_q == StEmit);
        o_pl_data   = o_pl_valid ? pl_buf_q[idx_q[IW-1:0]] : 8'd0;
        o_pl_last   = o_pl_valid && last_idx;
        o_frame_ok  = frame_ok_q;
        o_frame_err = frame_err_q;
        o_err_code  = err_code_q;
        o_busy      = (state_q != StHunt);
        o_ok_cnt    = ok_cnt_q;
        o_err_cnt   = err_cnt_q;
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a queue standing in for the receiver FIFO.
module tb_rx_frame_ctrl;

    localparam int unsigned TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_rx_ready;
    logic [7:0]  i_rx_data;
    logic        o_rx_read;
    logic        o_pl_valid;
    logic [7:0]  o_pl_data;
    logic        o_pl_last;
    logic        i_pl_ready;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [1:0]  o_err_code;
    logic        o_busy;
    logic [15:0] o_ok_cnt;
    logic [15:0] o_err_cnt;

    rx_frame_ctrl #(.MAX_LEN(16), .TIMEOUT(TMO), .HDR(8'hA5)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_ready  (i_rx_ready),
        .i_rx_data   (i_rx_data),
        .o_rx_read   (o_rx_read),
        .o_pl_valid  (o_pl_valid),
        .o_pl_data   (o_pl_data),
        .o_pl_last   (o_pl_last),
        .i_pl_ready  (i_pl_ready),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy),
        .o_ok_cnt    (o_ok_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] fifo [$];
    logic [7:0] got [$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n = 0;
    int rd_cnt, last_pop_cyc, err_cyc, first_valid_cyc, valid_cyc;
    int ok_pulses, err_pulses, rd_in_emit, stall_bad, last_cnt, last_pos;
    logic [7:0] err_hist;
    logic       bp_mode = 1'b0;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        i_rx_ready = (fifo.size() != 0);
        i_rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic clear_stats();
        got.delete();
        rd_cnt = 0; last_pop_cyc = -1; err_cyc = -1; first_valid_cyc = -1; valid_cyc = 0;
        ok_pulses = 0; err_pulses = 0; rd_in_emit = 0; stall_bad = 0;
        last_cnt = 0; last_pos = -1; err_hist = 8'h00; prev_stall = 1'b0;
    endtask

    function automatic logic [31:0] pack();
        logic [31:0] r = 32'h0;
        for (int i = 0; i < got.size() && i < 4; i++) r = {r[23:0], got[i]};
        return r;
    endfunction

    // One clock: observe at negedge, apply the FIFO pop and new inputs just after posedge.
    task automatic cyc();
        logic do_pop;
        @(negedge i_clk);
        do_pop = 1'b0;
        cyc_n++;
        if (o_rx_read) begin
            do_pop = 1'b1;
            rd_cnt++;
            last_pop_cyc = cyc_n;
            if (o_pl_valid) rd_in_emit++;
        end
        if (o_pl_valid) begin
            valid_cyc++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
            if (prev_stall && (o_pl_data !== prev_data || o_pl_last !== prev_last)) stall_bad++;
            if (i_pl_ready) begin
                got.push_back(o_pl_data);
                if (o_pl_last) begin
                    last_cnt++;
                    last_pos = got.size() - 1;
                end
            end
        end
        prev_stall = o_pl_valid && !i_pl_ready;
        prev_data  = o_pl_data;
        prev_last  = o_pl_last;
        if (o_frame_ok) ok_pulses++;
        if (o_frame_err) begin
            err_pulses++;
            err_cyc  = cyc_n;
            err_hist = {err_hist[5:0], o_err_code};
        end
        @(posedge i_clk);
        #1;
        if (do_pop) void'(fifo.pop_front());
        drive();
        if (bp_mode) i_pl_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_reads(input int target, input int budget);
        int k = 0;
        while (rd_cnt < target && k < budget) begin
            cyc();
            k++;
        end
        check("reads_reached", 32'(rd_cnt >= target), 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    initial begin
        i_rst = 1'b1; i_rx_ready = 1'b0; i_rx_data = 8'h00; i_pl_ready = 1'b1;
        clear_stats();
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_pl_valid), 32'd0);
        check("rst_counts", {o_ok_cnt, o_err_cnt}, 32'd0);
        check("rst_code", 32'(o_err_code), 32'd0);
        i_rst = 1'b0;

        // Good frame; check byte = -(03+11+22+33) mod 256 = 97
        clear_stats();
        foreach (fifo[i]) ;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        drive();
        run(20);
        check("good_data", pack(), 32'h00112233);
        check("good_size", 32'(got.size()), 32'd3);
        check("good_last_pos", 32'(last_pos), 32'd2);
        check("good_last_cnt", 32'(last_cnt), 32'd1);
        check("good_ok_pulse", 32'(ok_pulses), 32'd1);
        check("good_ok_cnt", 32'(o_ok_cnt), 32'd1);
        check("good_reads", 32'(rd_cnt), 32'd6);
        check("good_emit_lat", 32'(first_valid_cyc - last_pop_cyc), 32'd1);
        check("good_busy", 32'(o_busy), 32'd0);

        // Bad checksum: 02+10+20+00 != 0
        clear_stats();
        push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
        drive();
        run(15);
        check("bad_err_pulse", 32'(err_pulses), 32'd1);
        check("bad_code", 32'(o_err_code), 32'd2);
        check("bad_no_valid", 32'(valid_cyc), 32'd0);
        check("bad_err_cnt", 32'(o_err_cnt), 32'd1);
        check("bad_busy", 32'(o_busy), 32'd0);

        // Garbage, zero length, then 17 > MAX_LEN
        clear_stats();
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h00); push(8'hA5); push(8'h11);
        drive();
        run(15);
        check("len_err_pulses", 32'(err_pulses), 32'd2);
        check("len_codes", 32'(err_hist), 32'h05);
        check("len_err_cnt", 32'(o_err_cnt), 32'd3);
        check("len_reads", 32'(rd_cnt), 32'd6);

        // Stall after the first payload byte: expiry TMO cycles after the pop, pulse one later
        clear_stats();
        push(8'hA5); push(8'h02); push(8'hAA);
        drive();
        run(TMO + 8);
        check("tmo_pulse", 32'(err_pulses), 32'd1);
        check("tmo_code", 32'(o_err_code), 32'd3);
        check("tmo_timing", 32'(err_cyc - last_pop_cyc), 32'(TMO + 1));
        check("tmo_err_cnt", 32'(o_err_cnt), 32'd4);

        // Byte arriving in the expiry cycle is taken; 02+AA+BB+99 = 0x200
        clear_stats();
        push(8'hA5); push(8'h02); push(8'hAA);
        drive();
        wait_reads(3, 20);
        run(TMO - 1);
        push(8'hBB); push(8'h99);
        drive();
        run(12);
        check("exp_no_err", 32'(err_pulses), 32'd0);
        check("exp_data", pack(), 32'h0000AABB);
        check("exp_ok", 32'(ok_pulses), 32'd1);

        // Backpressure with trailing bytes waiting in the FIFO; 04+01+02+03+04+F2 = 0x100
        clear_stats();
        push(8'hA5); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        push(8'hF2); push(8'h00); push(8'h00);
        drive();
        bp_mode = 1'b1;
        run(40);
        bp_mode = 1'b0;
        i_pl_ready = 1'b1;
        check("bp_data", pack(), 32'h01020304);
        check("bp_size", 32'(got.size()), 32'd4);
        check("bp_stable", 32'(stall_bad), 32'd0);
        check("bp_no_emit_read", 32'(rd_in_emit), 32'd0);
        check("bp_last_pos", 32'(last_pos), 32'd3);
        check("bp_ok_cnt", 32'(o_ok_cnt), 32'd3);
        check("bp_reads", 32'(rd_cnt), 32'd9);

        // Reset in DATA with bytes still pending
        clear_stats();
        push(8'hA5); push(8'h05); push(8'h01); push(8'h02); push(8'h03);
        drive();
        wait_reads(4, 20);
        i_rst = 1'b1;
        #1;
        check("mid_busy", 32'(o_busy), 32'd0);
        check("mid_read", 32'(o_rx_read), 32'd0);
        check("mid_counts", {o_ok_cnt, o_err_cnt}, 32'd0);
        check("mid_code", 32'(o_err_code), 32'd0);
        check("mid_pulses", 32'({o_frame_ok, o_frame_err, o_pl_valid}), 32'd0);
        run(2);
        fifo.delete();
        drive();
        i_rst = 1'b0;
        push(8'hA5); push(8'h01); push(8'h05); push(8'hFA);
        drive();
        run(12);
        check("post_data", pack(), 32'h00000005);
        check("post_size", 32'(got.size()), 32'd1);
        check("post_ok_cnt", 32'(o_ok_cnt), 32'd1);
        check("post_no_err", 32'(err_pulses), 32'd0);
        check("post_err_cnt", 32'(o_err_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
